// File: rtl/alarm_pkg.sv
// Shared types and constants for the vehicle alarm zone controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_ARMING     = 3'd1,
        ST_SET        = 3'd2,
        ST_TRIGGER    = 3'd3,
        ST_ALARM      = 3'd4,
        ST_STOP_ALARM = 3'd5
    } alarm_state_t;

    localparam logic [1:0] ADDR_T_ARM       = 2'd0;
    localparam logic [1:0] ADDR_T_DRIVER    = 2'd1;
    localparam logic [1:0] ADDR_T_PASSENGER = 2'd2;
    localparam logic [1:0] ADDR_T_ALARM     = 2'd3;

    localparam int DEF_T_ARM       = 6;
    localparam int DEF_T_DRIVER    = 8;
    localparam int DEF_T_PASSENGER = 14;
    localparam int DEF_T_ALARM     = 10;

    localparam logic [2:0] SIREN_OFF   = 3'b000;
    localparam logic [2:0] SIREN_FIRST = 3'b001;

    // 001 -> 010 -> 100 -> 001
    function automatic logic [2:0] siren_next(input logic [2:0] s);
        return {s[1:0], s[2]};
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Tick prescaler plus loadable down-counter; expired marks the tick on which
// the count is 1. Loading restarts the prescaler.
module alarm_timer #(
    parameter int TW       = 4,
    parameter int TICK_DIV = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          tick,
    output logic          expired
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0]   presc_q;
    logic [TW-1:0] count_q;

    assign tick    = (presc_q == DIV_LAST);
    assign expired = tick && (count_q == TW'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (load) begin
            presc_q <= '0;
            // a zero delay would never expire, so it behaves as one tick
            count_q <= (value == '0) ? TW'(1) : value;
        end else if (tick) begin
            presc_q <= '0;
            if (count_q != '0)
                count_q <= count_q - TW'(1);
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

endmodule

// File: rtl/alarm_zones.sv
// Door-zone alarm sequencer with delay register file and siren pattern.
// Optional ZONE_LATCH_EN adds first_zone, the zone that caused the trigger.
//
// state         | meaning
// --------------+-----------------------------------------------
// DISARMED      | idle, ignition on or a door open; config writable
// ARMING        | exit delay running, doors must stay closed
// SET           | armed, watching all zones
// TRIGGER       | entry delay running after a door opened
// ALARM         | siren active while any door is open
// STOP_ALARM    | doors closed, siren runs out T_ALARM then re-arms
module alarm_zones
    import alarm_pkg::*;
#(
    parameter int N_ZONES  = 2,
    parameter int TW       = 4,
    parameter int TICK_DIV = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ignition,
    input  logic [N_ZONES-1:0] zone_open,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [TW-1:0]      cfg_data,
    output logic               set,
    output logic [2:0]         siren,
    output logic [2:0]         state,
    output logic               cfg_err
`ifdef ZONE_LATCH_EN
    ,
    output logic [N_ZONES-1:0] first_zone
`endif
);

    alarm_state_t  state_q, state_d;
    logic [TW-1:0] t_arm_q, t_driver_q, t_pass_q, t_alarm_q;
    logic          load;
    logic [TW-1:0] load_val;
    logic          tick, expired;
    logic          any_open;
    logic [2:0]    siren_q;
    logic          cfg_err_q;

    assign any_open = |zone_open;

    always_ff @(posedge clock) begin
        if (!reset) begin
            t_arm_q    <= TW'(DEF_T_ARM);
            t_driver_q <= TW'(DEF_T_DRIVER);
            t_pass_q   <= TW'(DEF_T_PASSENGER);
            t_alarm_q  <= TW'(DEF_T_ALARM);
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && (state_q != ST_DISARMED);
            if (cfg_we && state_q == ST_DISARMED) begin
                case (cfg_addr)
                    ADDR_T_ARM:       t_arm_q    <= cfg_data;
                    ADDR_T_DRIVER:    t_driver_q <= cfg_data;
                    ADDR_T_PASSENGER: t_pass_q   <= cfg_data;
                    ADDR_T_ALARM:     t_alarm_q  <= cfg_data;
                endcase
            end
        end
    end

    alarm_timer #(
        .TW       (TW),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .value   (load_val),
        .tick    (tick),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            state_q <= ST_DISARMED;
        else
            state_q <= state_d;
    end

    // ignition dominates every timed state; a door open in ARMING beats expiry
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = t_arm_q;
        case (state_q)
            ST_DISARMED: begin
                if (!ignition && !any_open) begin
                    state_d = ST_ARMING;
                    load    = 1'b1;
                end
            end
            ST_ARMING: begin
                if (ignition) begin
                    state_d = ST_DISARMED;
                end else if (any_open) begin
                    load = 1'b1;
                end else if (expired) begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                if (any_open) begin
                    state_d  = ST_TRIGGER;
                    load     = 1'b1;
                    load_val = zone_open[0] ? t_driver_q : t_pass_q;
                end
            end
            ST_TRIGGER: begin
                if (ignition)
                    state_d = ST_DISARMED;
                else if (expired)
                    state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (ignition) begin
                    state_d = ST_DISARMED;
                end else if (!any_open) begin
                    state_d  = ST_STOP_ALARM;
                    load     = 1'b1;
                    load_val = t_alarm_q;
                end
            end
            ST_STOP_ALARM: begin
                if (ignition)
                    state_d = ST_DISARMED;
                else if (any_open)
                    state_d = ST_ALARM;
                else if (expired)
                    state_d = ST_SET;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // pattern restarts only on a fresh alarm; STOP_ALARM <-> ALARM keeps phase
    always_ff @(posedge clock) begin
        if (!reset) begin
            siren_q <= SIREN_OFF;
        end else if (state_q == ST_TRIGGER && state_d == ST_ALARM) begin
            siren_q <= SIREN_FIRST;
        end else if (state_d == ST_ALARM || state_d == ST_STOP_ALARM) begin
            if (tick)
                siren_q <= siren_next(siren_q);
        end else begin
            siren_q <= SIREN_OFF;
        end
    end

`ifdef ZONE_LATCH_EN
    logic [N_ZONES-1:0] first_zone_q;

    always_ff @(posedge clock) begin
        if (!reset)
            first_zone_q <= '0;
        else if (state_d == ST_DISARMED && state_q != ST_DISARMED)
            first_zone_q <= '0;
        else if (state_q == ST_SET && state_d == ST_TRIGGER)
            first_zone_q <= zone_open & (~zone_open + N_ZONES'(1));
    end

    assign first_zone = first_zone_q;
`endif

    assign set     = (state_q == ST_SET) || (state_q == ST_TRIGGER);
    assign siren   = siren_q;
    assign state   = state_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_alarm_zones.sv
// Scoreboard bench: two alarm_zones instances (TICK_DIV 1 and 4); expected
// output events are queued by the stimulus and matched by negedge monitors.
module tb_alarm_zones;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_DIS = 3'd0, S_ARM = 3'd1, S_SET = 3'd2,
                           S_TRG = 3'd3, S_ALM = 3'd4, S_STP = 3'd5;

    logic       reset_a, ignition_a, cfg_we_a, set_a, cfg_err_a;
    logic [1:0] zone_a, cfg_addr_a;
    logic [3:0] cfg_data_a;
    logic [2:0] siren_a, state_a;
    logic       reset_b, ignition_b, cfg_we_b, set_b, cfg_err_b;
    logic [1:0] zone_b, cfg_addr_b;
    logic [3:0] cfg_data_b;
    logic [2:0] siren_b, state_b;
`ifdef ZONE_LATCH_EN
    logic [1:0] fz_a, fz_b;
`endif

    alarm_zones #(.N_ZONES(2), .TW(4), .TICK_DIV(1)) dut_a (
        .clock(clock), .reset(reset_a), .ignition(ignition_a), .zone_open(zone_a),
        .cfg_we(cfg_we_a), .cfg_addr(cfg_addr_a), .cfg_data(cfg_data_a),
        .set(set_a), .siren(siren_a), .state(state_a), .cfg_err(cfg_err_a)
`ifdef ZONE_LATCH_EN
        , .first_zone(fz_a)
`endif
    );

    alarm_zones #(.N_ZONES(2), .TW(4), .TICK_DIV(4)) dut_b (
        .clock(clock), .reset(reset_b), .ignition(ignition_b), .zone_open(zone_b),
        .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
        .set(set_b), .siren(siren_b), .state(state_b), .cfg_err(cfg_err_b)
`ifdef ZONE_LATCH_EN
        , .first_zone(fz_b)
`endif
    );

    typedef struct {
        logic [2:0] st;
        logic [2:0] sr;
        logic       ce;
        int         at;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    bit mon_a = 1'b0, mon_b = 1'b0;
    logic [6:0] prev_a, prev_b;
    ev_t e_a, e_b;

    function automatic logic exp_set(input logic [2:0] st);
        return (st == S_SET) || (st == S_TRG);
    endfunction

    task automatic push_a(input logic [2:0] st, input logic [2:0] sr, input logic ce, input int at);
        ev_t e;
        e.st = st; e.sr = sr; e.ce = ce; e.at = at;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [2:0] st, input logic [2:0] sr, input logic ce, input int at);
        ev_t e;
        e.st = st; e.sr = sr; e.ce = ce; e.at = at;
        qb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic check_ev(input string nm, input logic [2:0] st, input logic [2:0] sr,
                            input logic ce, input logic sb, input int at, input ev_t e);
        checks++;
        if (st !== e.st || sr !== e.sr || ce !== e.ce || sb !== exp_set(e.st) || at != e.at) begin
            errors++;
            $display("FAIL %s: got state=%0d siren=%b cfg_err=%b set=%b cyc=%0d, expected state=%0d siren=%b cfg_err=%b set=%b cyc=%0d",
                     nm, st, sr, ce, sb, at, e.st, e.sr, e.ce, exp_set(e.st), e.at);
        end
    endtask

    always @(negedge clock) begin
        if (mon_a && {state_a, siren_a, cfg_err_a} != prev_a) begin
            prev_a = {state_a, siren_a, cfg_err_a};
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL ev_a: unexpected state=%0d siren=%b cfg_err=%b at cyc %0d, expected no event",
                         state_a, siren_a, cfg_err_a, cyc);
            end else begin
                e_a = qa.pop_front();
                check_ev("ev_a", state_a, siren_a, cfg_err_a, set_a, cyc, e_a);
            end
        end
    end

    always @(negedge clock) begin
        if (mon_b && {state_b, siren_b, cfg_err_b} != prev_b) begin
            prev_b = {state_b, siren_b, cfg_err_b};
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL ev_b: unexpected state=%0d siren=%b cfg_err=%b at cyc %0d, expected no event",
                         state_b, siren_b, cfg_err_b, cyc);
            end else begin
                e_b = qb.pop_front();
                check_ev("ev_b", state_b, siren_b, cfg_err_b, set_b, cyc, e_b);
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic seq_a();
        int c;
        logic [2:0] pat [3];
        pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b100;
        reset_a = 1'b0; ignition_a = 1'b1; zone_a = 2'b00;
        cfg_we_a = 1'b0; cfg_addr_a = 2'd0; cfg_data_a = 4'd0;
        nclk(3);
        chk("rst_state_a", 8'(state_a), 8'(S_DIS));
        chk("rst_set_a", 8'(set_a), 8'd0);
        chk("rst_siren_a", 8'(siren_a), 8'd0);
        chk("rst_cfg_err_a", 8'(cfg_err_a), 8'd0);
`ifdef ZONE_LATCH_EN
        chk("rst_first_zone_a", 8'(fz_a), 8'd0);
`endif
        reset_a = 1'b1;
        prev_a = {state_a, siren_a, cfg_err_a};
        mon_a = 1'b1;
        nclk(1);

        // arm with default T_ARM=6
        c = cyc; ignition_a = 1'b0;
        push_a(S_ARM, 3'b000, 1'b0, c + 1);
        push_a(S_SET, 3'b000, 1'b0, c + 7);
        wait_to(c + 8);

        // passenger door: T_PASSENGER=14, then siren runs, close -> T_ALARM=10
        c = cyc; zone_a = 2'b10;
        push_a(S_TRG, 3'b000, 1'b0, c + 1);
        push_a(S_ALM, 3'b001, 1'b0, c + 15);
        push_a(S_ALM, 3'b010, 1'b0, c + 16);
        push_a(S_ALM, 3'b100, 1'b0, c + 17);
        wait_to(c + 17);
        zone_a = 2'b00;
        for (int k = 0; k < 10; k++)
            push_a(S_STP, pat[k % 3], 1'b0, c + 18 + k);
        push_a(S_SET, 3'b000, 1'b0, c + 28);
        wait_to(c + 29);

        // STOP_ALARM reopened on its 5th clock, then ignition disarms
        c = cyc; zone_a = 2'b10;
        push_a(S_TRG, 3'b000, 1'b0, c + 1);
        push_a(S_ALM, 3'b001, 1'b0, c + 15);
        push_a(S_ALM, 3'b010, 1'b0, c + 16);
        push_a(S_ALM, 3'b100, 1'b0, c + 17);
        wait_to(c + 17);
        zone_a = 2'b00;
        for (int k = 0; k < 5; k++)
            push_a(S_STP, pat[k % 3], 1'b0, c + 18 + k);
        wait_to(c + 22);
        zone_a = 2'b01;
        push_a(S_ALM, 3'b100, 1'b0, c + 23);
        wait_to(c + 23);
        ignition_a = 1'b1;
        push_a(S_DIS, 3'b000, 1'b0, c + 24);
        wait_to(c + 25);
        zone_a = 2'b00;

        // write T_ARM=3 while disarmed
        cfg_we_a = 1'b1; cfg_addr_a = 2'd0; cfg_data_a = 4'd3;
        nclk(1);
        cfg_we_a = 1'b0;
        nclk(1);
        c = cyc; ignition_a = 1'b0;
        push_a(S_ARM, 3'b000, 1'b0, c + 1);
        push_a(S_SET, 3'b000, 1'b0, c + 4);
        wait_to(c + 4);

        // write attempted in SET is rejected
        c = cyc;
        cfg_we_a = 1'b1; cfg_addr_a = 2'd2; cfg_data_a = 4'd2;
        push_a(S_SET, 3'b000, 1'b1, c + 1);
        push_a(S_SET, 3'b000, 1'b0, c + 2);
        nclk(1);
        cfg_we_a = 1'b0;
        wait_to(c + 2);
        c = cyc; zone_a = 2'b10;
        push_a(S_TRG, 3'b000, 1'b0, c + 1);
        push_a(S_ALM, 3'b001, 1'b0, c + 15);
        wait_to(c + 15);
        ignition_a = 1'b1;
        push_a(S_DIS, 3'b000, 1'b0, c + 16);
        wait_to(c + 16);
        zone_a = 2'b00;
        nclk(1);

        // door blip during ARMING reloads T_ARM=3
        c = cyc; ignition_a = 1'b0;
        push_a(S_ARM, 3'b000, 1'b0, c + 1);
        wait_to(c + 2);
        zone_a = 2'b01;
        wait_to(c + 3);
        zone_a = 2'b00;
        push_a(S_SET, 3'b000, 1'b0, c + 6);
        wait_to(c + 6);

        // both doors together: driver delay 8 wins
        c = cyc; zone_a = 2'b11;
        push_a(S_TRG, 3'b000, 1'b0, c + 1);
        push_a(S_ALM, 3'b001, 1'b0, c + 9);
        wait_to(c + 5);
`ifdef ZONE_LATCH_EN
        chk("first_zone_a", 8'(fz_a), 8'h01);
`endif
        wait_to(c + 9);
        ignition_a = 1'b1;
        push_a(S_DIS, 3'b000, 1'b0, c + 10);
        wait_to(c + 11);
`ifdef ZONE_LATCH_EN
        chk("first_zone_clr_a", 8'(fz_a), 8'h00);
`endif
        zone_a = 2'b00;
    endtask

    task automatic seq_b();
        int c;
        reset_b = 1'b0; ignition_b = 1'b1; zone_b = 2'b00;
        cfg_we_b = 1'b0; cfg_addr_b = 2'd0; cfg_data_b = 4'd0;
        nclk(3);
        chk("rst_state_b", 8'(state_b), 8'(S_DIS));
        chk("rst_siren_b", 8'(siren_b), 8'd0);
        reset_b = 1'b1;
        prev_b = {state_b, siren_b, cfg_err_b};
        mon_b = 1'b1;
        nclk(1);

        cfg_we_b = 1'b1; cfg_addr_b = 2'd0; cfg_data_b = 4'd2;
        nclk(1);
        cfg_we_b = 1'b0;
        nclk(1);

        // T_ARM=2 ticks of 4 clocks
        c = cyc; ignition_b = 1'b0;
        push_b(S_ARM, 3'b000, 1'b0, c + 1);
        push_b(S_SET, 3'b000, 1'b0, c + 9);
        wait_to(c + 9);

        // passenger delay 14 ticks = 56 clocks, then reset mid-alarm with a write
        c = cyc; zone_b = 2'b10;
        push_b(S_TRG, 3'b000, 1'b0, c + 1);
        push_b(S_ALM, 3'b001, 1'b0, c + 57);
        wait_to(c + 58);
        reset_b = 1'b0; ignition_b = 1'b1; zone_b = 2'b00;
        cfg_we_b = 1'b1; cfg_addr_b = 2'd0; cfg_data_b = 4'd1;
        push_b(S_DIS, 3'b000, 1'b0, c + 59);
        nclk(1);
        reset_b = 1'b1; cfg_we_b = 1'b0;
        nclk(1);

        // default T_ARM=6 restored: 24 clocks
        c = cyc; ignition_b = 1'b0;
        push_b(S_ARM, 3'b000, 1'b0, c + 1);
        push_b(S_SET, 3'b000, 1'b0, c + 25);
        wait_to(c + 26);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cyc %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            seq_a();
            seq_b();
        join
        nclk(3);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL pending_a: %0d expected events never seen, expected 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL pending_b: %0d expected events never seen, expected 0", qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_zones.md
ALARM_ZONES -- requirements
Module: alarm_zones

Interface
REQ-001 Parameter N_ZONES, default 2, number of door/entry zones (1..8); zone 0 is the driver door.
REQ-002 Parameter TW, default 4, width of every delay register and of the delay counter (2..16).
REQ-003 Parameter TICK_DIV, default 1, clocks per timing tick (1..65535).
REQ-004 clock  in  1  single system clock; all logic rises on posedge clock.
REQ-005 reset  in  1  synchronous, active-low reset; sampled only on posedge clock.
REQ-006 ignition  in  1  ignition on, pre-debounced, synchronous to clock.
REQ-007 zone_open  in  N_ZONES  per-zone door open, pre-debounced, synchronous to clock.
REQ-008 cfg_we  in  1  delay-register write strobe, one clock per write.
REQ-009 cfg_addr  in  2  register select: 0 T_ARM, 1 T_DRIVER, 2 T_PASSENGER, 3 T_ALARM.
REQ-010 cfg_data  in  TW  write data.
REQ-011 set  out  1  high in SET and TRIGGER.
REQ-012 siren  out  3  colour pattern; 3'b000 outside ALARM and STOP_ALARM.
REQ-013 state  out  3  current state encoding from the shared package.
REQ-014 cfg_err  out  1  one-clock pulse when a write is rejected.

Function
REQ-015 States: DISARMED, ARMING, SET, TRIGGER, ALARM, STOP_ALARM; one transition per clock maximum.
REQ-016 DISARMED -> ARMING when ignition low and all zones closed; otherwise stays.
REQ-017 ARMING: loads T_ARM on entry; ignition high -> DISARMED; any zone open reloads T_ARM and stays; expiry -> SET.
REQ-018 SET: any zone open -> TRIGGER; loads T_DRIVER if zone 0 open, else T_PASSENGER; zone 0 wins when several open together.
REQ-019 TRIGGER: ignition high -> DISARMED; expiry -> ALARM; zones opening during TRIGGER do not reload.
REQ-020 ALARM: ignition high -> DISARMED; all zones closed -> STOP_ALARM, loading T_ALARM.
REQ-021 STOP_ALARM: ignition high -> DISARMED; any zone open -> ALARM; expiry with all closed -> SET.
REQ-022 Ignition high has priority over every other condition in ARMING, TRIGGER, ALARM and STOP_ALARM.
REQ-023 A timing tick is one clock in every TICK_DIV; the prescaler restarts on every counter load.
REQ-024 Counter loads value T, decrements on each tick; expiry is the clock on which it is 1 and a tick occurs; a loaded 0 is treated as 1.
REQ-025 With TICK_DIV=1, a delay of T leaves the state exactly T clocks after entering it.
REQ-026 siren cycles 001 -> 010 -> 100 -> 001 on each tick in ALARM/STOP_ALARM, starting at 001 on ALARM entry from TRIGGER.
REQ-027 Writes are accepted only in DISARMED; cfg_data is written to the register selected by cfg_addr on the clock after cfg_we.
REQ-028 A write in any other state is discarded and pulses cfg_err for one clock, starting the clock after cfg_we.
REQ-029 A new delay value takes effect at the next load; a running count is never altered.

Reset
REQ-030 Reset low: state DISARMED, set 0, siren 000, cfg_err 0, counter and prescaler 0.
REQ-031 Reset low restores T_ARM=6, T_DRIVER=8, T_PASSENGER=14, T_ALARM=10, truncated to TW bits.
REQ-032 Reset low mid-alarm forces DISARMED on the same edge and silences siren; reset has priority over cfg_we.

Configuration
REQ-033 Macro ZONE_LATCH_EN, when defined, adds output first_zone[N_ZONES-1:0] holding the one-hot zone that caused SET -> TRIGGER (lowest index wins).
REQ-034 first_zone clears to 0 on reset and on entry to DISARMED, and holds through TRIGGER/ALARM/STOP_ALARM/SET.
REQ-035 Without ZONE_LATCH_EN the port and its register do not exist; all other behaviour is identical.

Structure
REQ-036 Shared package alarm_pkg holds the state enum, cfg_addr constants and the default delay values.
REQ-037 Sub-module alarm_timer implements the prescaler and loadable down-counter (ports: load, value, expired).

Verification
REQ-038 Defaults, TICK_DIV=1: ignition low, doors closed -> ARMING, SET 6 clocks later; set=1.
REQ-039 In SET open zone 1 -> TRIGGER, ALARM 14 clocks later; siren 001,010,100; close all -> STOP_ALARM, SET after 10 clocks.
REQ-040 In STOP_ALARM reopen zone 0 at clock 5 -> ALARM; ignition high -> DISARMED, siren 000 next clock.
REQ-041 In SET open zones 0 and 1 together -> T_DRIVER=8 used; first_zone=01 with ZONE_LATCH_EN.
REQ-042 DISARMED write T_ARM=3 -> next arming takes 3 clocks; write in SET -> cfg_err pulse, registers unchanged.
REQ-043 TICK_DIV=4, T_ARM=2 -> SET exactly 8 clocks after ARMING entry; reset low in ALARM -> DISARMED, defaults restored.
